rr_mux_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one 8:1 bit multiplexer among 8 requesters.
- Picks one requester, drives the mux select and a one-hot grant, and presents the selected data bit on a valid/ready output handshake.
- Holds each grant until the downstream consumer accepts the bit, then rotates priority.
- Sits between the requester bank and the shared mux/consumer; the mux itself stays combinational.

---
 rtl/rr_mux_arbiter_if.sv | 36 +++
 rtl/rr_mux_arbiter.sv | 93 +++++++++
 tb/tb_rr_mux_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if
//   Bundles the requester bank, the shared-mux select/grant and the
//   valid/ready output handshake of the round-robin mux arbiter.
//   Ports carried:
//     req[N]       request bit per requester          (bank -> arbiter)
//     in[N]        data bit per requester (mux input) (bank -> arbiter)
//     out_ready    consumer accepts out_data          (consumer -> arbiter)
//     gnt[N]       one-hot grant                      (arbiter -> bank)
//     sel[SELW]    mux select                         (arbiter -> mux)
//     out_valid    out_data holds a granted bit       (arbiter -> consumer)
//     out_data     selected data bit                  (arbiter -> consumer)
//     busy         status, mirrors out_valid          (arbiter -> status)
//   Modports: master = requester/consumer side, slave = arbiter side.
interface rr_mux_arbiter_if #(
  parameter int N    = 8,
  parameter int SELW = 3
);
  logic [N-1:0]    req;
  logic [N-1:0]    in;
  logic            out_ready;
  logic [N-1:0]    gnt;
  logic [SELW-1:0] sel;
  logic            out_valid;
  logic            out_data;
  logic            busy;

  modport master (
    output req, in, out_ready,
    input  gnt, sel, out_valid, out_data, busy
  );

  modport slave (
    input  req, in, out_ready,
    output gnt, sel, out_valid, out_data, busy
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter that shares one combinational 8:1 bit mux among N
//   requesters. A winner is picked by scanning from the priority pointer,
//   its grant and mux select are registered, and the selected bit is offered
//   on a valid/ready handshake. The grant is held until the consumer accepts,
//   then the pointer moves past the served requester and a new winner is
//   chosen on the same edge, so back-to-back grants have no bubble.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous reset, active-high
//     bus   rr_mux_arbiter_if.slave (req, in, out_ready in;
//           gnt, sel, out_valid, out_data, busy out)
module rr_mux_arbiter #(
  parameter int N    = 8,
  parameter int SELW = 3
) (
  input logic              clk,
  input logic              rst,
  rr_mux_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [N-1:0]    gnt_q, gnt_d;

  logic            out_valid;
  logic            handshake;
  logic [SELW-1:0] scan_ptr;
  logic            win_found;
  logic [SELW-1:0] win_idx;

  // Returns {found, index} of the first set request scanning ptr, ptr+1, ...
  // N is a power of two, so SELW-bit addition wraps modulo N for free.
  function automatic logic [SELW:0] rr_pick(input logic [N-1:0] r,
                                            input logic [SELW-1:0] p);
    logic [SELW-1:0] idx;
    rr_pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = p + SELW'(k);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign out_valid = (state_q == GRANT);
  assign handshake = out_valid && bus.out_ready;
  // On a handshake the pointer moves past the served requester before the
  // same-edge re-arbitration, giving it lowest priority next round.
  assign scan_ptr  = handshake ? sel_q + SELW'(1) : ptr_q;
  assign {win_found, win_idx} = rr_pick(bus.req, scan_ptr);

  always_comb begin
    state_d = state_q;
    ptr_d   = scan_ptr;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    // Re-arbitrate only when not holding a grant; a granted requester
    // cannot withdraw or be pre-empted until its bit is accepted.
    if (!out_valid || handshake) begin
      if (win_found) begin
        state_d = GRANT;
        sel_d   = win_idx;
        gnt_d   = N'(1) << win_idx;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid;
  assign bus.busy      = out_valid;
  assign bus.out_data  = out_valid & bus.in[sel_q];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;
  localparam int N    = 8;
  localparam int SELW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.N(N), .SELW(SELW)) bus ();

  rr_mux_arbiter #(.N(N), .SELW(SELW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: who holds the grant, and where priority starts.
  bit m_valid = 1'b0;
  int m_sel   = 0;
  int m_ptr   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit hs;
    bit found;
    int w;
    if (rst) begin
      m_valid = 1'b0;
      m_sel   = 0;
      m_ptr   = 0;
    end else begin
      hs = m_valid && bus.out_ready;
      if (hs) m_ptr = (m_sel + 1) % N;
      if (!m_valid || hs) begin
        found = 1'b0;
        w     = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && bus.req[(m_ptr + k) % N]) begin
            found = 1'b1;
            w     = (m_ptr + k) % N;
          end
        end
        m_valid = found;
        if (found) m_sel = w;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("model_busy",      32'(bus.busy),      32'(m_valid));
      chk("model_gnt",       32'(bus.gnt),       m_valid ? (32'd1 << m_sel) : 32'd0);
      chk("model_sel",       32'(bus.sel),       32'(m_sel));
      chk("model_out_data",  32'(bus.out_data),  m_valid ? 32'(bus.in[m_sel]) : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rot_data;

  initial begin
    rst           = 1'b1;
    bus.req       = '0;
    bus.in        = '0;
    bus.out_ready = 1'b0;

    // Reset then idle
    tick();
    tick();
    chk_en = 1'b1;
    rst    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_gnt",       32'(bus.gnt),       32'd0);
      chk("idle_sel",       32'(bus.sel),       32'd0);
      chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_out_data",  32'(bus.out_data),  32'd0);
    end

    // Single request with data
    bus.in        = 8'b11101001;
    bus.req       = 8'b00001000;
    bus.out_ready = 1'b1;
    tick();
    chk("single_gnt",      32'(bus.gnt),      32'h08);
    chk("single_sel",      32'(bus.sel),      32'd3);
    chk("single_out_data", 32'(bus.out_data), 32'd1);
    bus.req = '0;
    tick();
    chk("single_done_valid", 32'(bus.out_valid), 32'd0);
    bus.req = 8'hFF;
    tick();
    chk("single_next_ptr_sel", 32'(bus.sel), 32'd4);

    // Rotation from reset
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    bus.req  = 8'hFF;
    rot_data = 8'b11101001;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("rot_sel",      32'(bus.sel),      32'(i % 8));
      chk("rot_out_data", 32'(bus.out_data), 32'(rot_data[i % 8]));
    end

    // Backpressure, then reset mid-grant
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    bus.req       = 8'b00100100;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_gnt", 32'(bus.gnt), 32'h04);
      chk("bp_sel", 32'(bus.sel), 32'd2);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_next_gnt", 32'(bus.gnt), 32'h20);
    chk("bp_next_sel", 32'(bus.sel), 32'd5);
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    tick();
    chk("rstmid_gnt",       32'(bus.gnt),       32'd0);
    chk("rstmid_out_valid", 32'(bus.out_valid), 32'd0);
    rst     = 1'b0;
    bus.req = 8'b00100010;
    tick();
    chk("rstmid_ptr0_sel", 32'(bus.sel), 32'd1);

    // Wrap and withdrawal
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    bus.req       = 8'b01000000;
    bus.out_ready = 1'b1;
    tick();
    chk("wrap_sel6", 32'(bus.sel), 32'd6);
    bus.req = 8'b10000001;
    tick();
    chk("wrap_sel7", 32'(bus.sel), 32'd7);
    tick();
    chk("wrap_sel0", 32'(bus.sel), 32'd0);
    bus.req = 8'b00000100;
    tick();
    chk("wd_sel2", 32'(bus.sel), 32'd2);
    bus.req       = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("wd_hold_gnt", 32'(bus.gnt), 32'h04);
      chk("wd_hold_sel", 32'(bus.sel), 32'd2);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("wd_release_valid", 32'(bus.out_valid), 32'd0);
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
